// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with per-register ready bits.
// Provides registered reads with write-to-read bypass and sticky write-conflict detection.
module phys_reg_file_mp #(
    parameter int unsigned WORD_SIZE       = 64,
    parameter int unsigned NUM_PHYS_REGS   = 128,
    parameter int unsigned NUM_READ_PORTS  = 4,
    parameter int unsigned NUM_WRITE_PORTS = 2,
    parameter int unsigned NUM_ALLOC_PORTS = 2,
    localparam int unsigned IDX_W          = $clog2(NUM_PHYS_REGS)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic [NUM_READ_PORTS-1:0]             rd_en_i,
    input  logic [NUM_READ_PORTS*IDX_W-1:0]       rd_idx_i,
    output logic [NUM_READ_PORTS-1:0]             rd_valid_o,
    output logic [NUM_READ_PORTS*WORD_SIZE-1:0]   rd_data_o,
    output logic [NUM_READ_PORTS-1:0]             rd_ready_o,
    input  logic [NUM_WRITE_PORTS-1:0]            wr_en_i,
    input  logic [NUM_WRITE_PORTS*IDX_W-1:0]      wr_idx_i,
    input  logic [NUM_WRITE_PORTS*WORD_SIZE-1:0]  wr_data_i,
    input  logic [NUM_ALLOC_PORTS-1:0]            alloc_en_i,
    input  logic [NUM_ALLOC_PORTS*IDX_W-1:0]      alloc_idx_i,
    output logic                                  wr_conflict_o
);

    logic [WORD_SIZE-1:0]                mem_q [NUM_PHYS_REGS];
    logic [WORD_SIZE-1:0]                mem_d [NUM_PHYS_REGS];
    logic [NUM_PHYS_REGS-1:0]            rdy_q, rdy_d;
    logic [NUM_READ_PORTS-1:0]           rd_valid_q;
    logic [NUM_READ_PORTS*WORD_SIZE-1:0] rd_data_q, rd_data_d;
    logic [NUM_READ_PORTS-1:0]           rd_ready_q, rd_ready_d;
    logic                                conflict_q, conflict_d;
    logic [IDX_W-1:0]                    ridx;

    // Index 0 is hardwired and out-of-range indices are inert.
    function automatic logic idx_ok(logic [IDX_W-1:0] idx);
        return (idx != '0) && (32'(idx) < NUM_PHYS_REGS);
    endfunction

    // Ascending port loop lets the highest-numbered write port win; allocs then flush follow.
    always_comb begin
        mem_d = mem_q;
        rdy_d = rdy_q;
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (wr_en_i[w] && idx_ok(wr_idx_i[w*IDX_W +: IDX_W])) begin
                mem_d[wr_idx_i[w*IDX_W +: IDX_W]] = wr_data_i[w*WORD_SIZE +: WORD_SIZE];
                rdy_d[wr_idx_i[w*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int a = 0; a < NUM_ALLOC_PORTS; a++) begin
            if (alloc_en_i[a] && idx_ok(alloc_idx_i[a*IDX_W +: IDX_W])) begin
                rdy_d[alloc_idx_i[a*IDX_W +: IDX_W]] = 1'b0;
            end
        end
        if (flush_i) begin
            rdy_d = '1;
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            for (int j = i + 1; j < NUM_WRITE_PORTS; j++) begin
                if (wr_en_i[i] && wr_en_i[j] &&
                    (wr_idx_i[i*IDX_W +: IDX_W] == wr_idx_i[j*IDX_W +: IDX_W]) &&
                    (wr_idx_i[i*IDX_W +: IDX_W] != '0)) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Reads look at the next-state arrays, which gives bypass and alloc-wins for free.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_ready_d = rd_ready_q;
        ridx       = '0;
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            ridx = rd_idx_i[r*IDX_W +: IDX_W];
            if (rd_en_i[r]) begin
                if (ridx == '0) begin
                    rd_data_d[r*WORD_SIZE +: WORD_SIZE] = '0;
                    rd_ready_d[r]                       = 1'b1;
                end else if (idx_ok(ridx)) begin
                    rd_data_d[r*WORD_SIZE +: WORD_SIZE] = mem_d[ridx];
                    rd_ready_d[r]                       = rdy_d[ridx];
                end else begin
                    rd_data_d[r*WORD_SIZE +: WORD_SIZE] = '0;
                    rd_ready_d[r]                       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                mem_q[i] <= '0;
            end
            rdy_q      <= '1;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            rd_ready_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rdy_q      <= rdy_d;
            rd_valid_q <= rd_en_i;
            rd_data_q  <= rd_data_d;
            rd_ready_q <= rd_ready_d;
            conflict_q <= conflict_d;
        end
    end

    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign rd_ready_o    = rd_ready_q;
    assign wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Scoreboard bench for phys_reg_file_mp: expected read results are queued at issue
// and compared one cycle later.
module tb_phys_reg_file_mp;

    localparam int W  = 64;
    localparam int N  = 128;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int NA = 2;
    localparam int IW = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [NR-1:0]   rd_en = '0;
    logic [NR*IW-1:0] rd_idx = '0;
    logic [NR-1:0]   rd_valid;
    logic [NR*W-1:0] rd_data;
    logic [NR-1:0]   rd_ready;
    logic [NW-1:0]   wr_en = '0;
    logic [NW*IW-1:0] wr_idx = '0;
    logic [NW*W-1:0] wr_data = '0;
    logic [NA-1:0]   alloc_en = '0;
    logic [NA*IW-1:0] alloc_idx = '0;
    logic            wr_conflict;

    phys_reg_file_mp dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .rd_en_i      (rd_en),
        .rd_idx_i     (rd_idx),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .rd_ready_o   (rd_ready),
        .wr_en_i      (wr_en),
        .wr_idx_i     (wr_idx),
        .wr_data_i    (wr_data),
        .alloc_en_i   (alloc_en),
        .alloc_idx_i  (alloc_idx),
        .wr_conflict_o(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;
        logic [W-1:0] data;
        logic         rdy;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_mem[N];
    logic         m_rdy[N];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = '0;
            m_rdy[i] = 1'b1;
        end
    endtask

    task automatic rd(input int p, input int idx);
        rd_en[p] = 1'b1;
        rd_idx[p*IW +: IW] = idx[IW-1:0];
    endtask

    task automatic wr(input int p, input int idx, input logic [W-1:0] d);
        wr_en[p] = 1'b1;
        wr_idx[p*IW +: IW] = idx[IW-1:0];
        wr_data[p*W +: W] = d;
    endtask

    task automatic al(input int p, input int idx);
        alloc_en[p] = 1'b1;
        alloc_idx[p*IW +: IW] = idx[IW-1:0];
    endtask

    // One clock: predict, queue expected reads, clock, compare, clear enables.
    task automatic step();
        logic [W-1:0]  nm[N];
        logic          nr[N];
        logic [NR-1:0] en_s;
        int            idx;
        exp_t          e;
        nm   = m_mem;
        nr   = m_rdy;
        en_s = rd_en;
        for (int w = 0; w < NW; w++) begin
            idx = int'(wr_idx[w*IW +: IW]);
            if (wr_en[w] && idx != 0) begin
                nm[idx] = wr_data[w*W +: W];
                nr[idx] = 1'b1;
            end
        end
        for (int a = 0; a < NA; a++) begin
            idx = int'(alloc_idx[a*IW +: IW]);
            if (alloc_en[a] && idx != 0) nr[idx] = 1'b0;
        end
        if (flush) for (int i = 0; i < N; i++) nr[i] = 1'b1;
        for (int r = 0; r < NR; r++) begin
            idx = int'(rd_idx[r*IW +: IW]);
            if (rd_en[r]) begin
                e.port = r;
                e.data = (idx == 0) ? '0 : nm[idx];
                e.rdy  = (idx == 0) ? 1'b1 : nr[idx];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        m_mem = nm;
        m_rdy = nr;
        for (int r = 0; r < NR; r++) begin
            n_tests++;
            if (rd_valid[r] !== en_s[r]) begin
                n_fail++;
                $display("FAIL rd_valid[%0d]: got %b expected %b", r, rd_valid[r], en_s[r]);
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (rd_data[e.port*W +: W] !== e.data || rd_ready[e.port] !== e.rdy) begin
                n_fail++;
                $display("FAIL read port %0d: got data=%h rdy=%b expected data=%h rdy=%b",
                         e.port, rd_data[e.port*W +: W], rd_ready[e.port], e.data, e.rdy);
            end
        end
        rd_en = '0; wr_en = '0; alloc_en = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_tests++;
        if (rd_valid !== '0 || rd_data !== '0 || rd_ready !== '0 || wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got v=%h rdy=%h c=%b data=%h expected all zero",
                     rd_valid, rd_ready, wr_conflict, rd_data);
        end
        rst_n = 1'b1;
        rd(0, 0); rd(1, 1); rd(2, 127); rd(3, 64);
        step();
    endtask

    task automatic test_write_read();
        wr(0, 5, 64'hDEAD);
        step();
        rd(0, 5);
        step();
        n_tests++;
        if (rd_data[0 +: W] !== 64'hDEAD || rd_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL write_read: got %h/%b expected DEAD/1", rd_data[0 +: W], rd_ready[0]);
        end
        step();
        n_tests++;
        if (rd_valid[0] !== 1'b0 || rd_data[0 +: W] !== 64'hDEAD || rd_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold: got v=%b d=%h r=%b expected 0/DEAD/1",
                     rd_valid[0], rd_data[0 +: W], rd_ready[0]);
        end
    endtask

    task automatic test_bypass();
        wr(0, 7, 64'h1234); rd(2, 7);
        step();
        n_tests++;
        if (rd_data[2*W +: W] !== 64'h1234 || rd_ready[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass: got %h/%b expected 1234/1", rd_data[2*W +: W], rd_ready[2]);
        end
        wr(1, 30, 64'h3); al(0, 30); rd(1, 30);
        step();
        n_tests++;
        if (rd_data[W +: W] !== 64'h3 || rd_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_wins: got %h/%b expected 3/0", rd_data[W +: W], rd_ready[1]);
        end
    endtask

    task automatic test_alloc();
        al(1, 9);
        step();
        rd(3, 9);
        step();
        n_tests++;
        if (rd_ready[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_busy: got %b expected 0", rd_ready[3]);
        end
        wr(1, 9, 64'h55);
        step();
        rd(3, 9);
        step();
        n_tests++;
        if (rd_data[3*W +: W] !== 64'h55 || rd_ready[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL alloc_write: got %h/%b expected 55/1", rd_data[3*W +: W], rd_ready[3]);
        end
    endtask

    task automatic test_flush();
        al(0, 3); al(1, 4);
        step();
        flush = 1'b1; al(0, 40);
        step();
        rd(0, 3); rd(1, 4); rd(2, 40);
        step();
        n_tests++;
        if (rd_ready[2:0] !== 3'b111) begin
            n_fail++;
            $display("FAIL flush: got %b expected 111", rd_ready[2:0]);
        end
    endtask

    task automatic test_conflict();
        wr(0, 0, 64'hFF); wr(1, 0, 64'hEE); al(0, 0);
        step();
        rd(0, 0);
        step();
        n_tests++;
        if (wr_conflict !== 1'b0 || rd_data[0 +: W] !== '0 || rd_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL idx0: got c=%b d=%h r=%b expected 0/0/1",
                     wr_conflict, rd_data[0 +: W], rd_ready[0]);
        end
        wr(0, 12, 64'hA); wr(1, 12, 64'hB);
        step();
        rd(1, 12);
        step();
        n_tests++;
        if (wr_conflict !== 1'b1 || rd_data[W +: W] !== 64'hB) begin
            n_fail++;
            $display("FAIL conflict: got c=%b d=%h expected 1/B", wr_conflict, rd_data[W +: W]);
        end
        step(); step();
        n_tests++;
        if (wr_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_sticky: got %b expected 1", wr_conflict);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int w = 0; w < NW; w++)
                if ($urandom_range(0, 1) == 1)
                    wr(w, int'($urandom_range(0, 31)), {$urandom, $urandom});
            for (int a = 0; a < NA; a++)
                if ($urandom_range(0, 3) == 0) al(a, int'($urandom_range(0, 31)));
            for (int r = 0; r < NR; r++)
                if ($urandom_range(0, 2) != 0) rd(r, int'($urandom_range(0, 31)));
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
    endtask

    task automatic test_reset_mid();
        wr(0, 5, 64'h77); rd(0, 5); rd(1, 12);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (rd_valid !== '0 || rd_data !== '0 || rd_ready !== '0 || wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%h r=%h c=%b expected zero",
                     rd_valid, rd_ready, wr_conflict);
        end
        model_reset();
        #3;
        rst_n = 1'b1;
        step();
        rd(0, 5); rd(1, 12); rd(2, 7); rd(3, 9);
        step();
        n_tests++;
        if (rd_data !== '0 || rd_ready !== 4'b1111) begin
            n_fail++;
            $display("FAIL after_reset: got d=%h r=%b expected 0/1111", rd_data, rd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_alloc();
        test_flush();
        test_conflict();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
